// File: rtl/sw_edge_irq_pkg.sv
// Shared constants for the switch edge/interrupt controller: register map
// word addresses and the default debounce interval.
package sw_edge_irq_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE_CFG = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    // 1 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/sw_edge_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch controller; readdata is the
// only slave-driven signal.
interface sw_edge_irq_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchroniser followed by a stability counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive agreeing samples.
module sw_debounce
    import sw_edge_irq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable
);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            // Any sample agreeing with the accepted level restarts the count
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_edge_irq_ctrl.sv
// Switch conditioning slave: debounced levels, per-bit rise/fall edge capture
// with write-1-to-clear, and a masked level interrupt for the Nios II.
module sw_edge_irq_ctrl
    import sw_edge_irq_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    sw_edge_irq_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    logic [WIDTH-1:0]   stable;
    logic [WIDTH-1:0]   stable_d;
    logic [WIDTH-1:0]   ev;
    logic [WIDTH-1:0]   clr;
    logic [2*WIDTH-1:0] edge_cfg;
    logic [WIDTH-1:0]   irqmask;
    logic [WIDTH-1:0]   edgecapture;
    logic [31:0]        rd_mux;
    logic               wr;
    logic               unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .stable (stable[i])
        );
    end

    assign wr  = bus.chipselect & ~bus.write_n;
    assign clr = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign ev  = (stable & ~stable_d & edge_cfg[WIDTH-1:0]) |
                 (~stable & stable_d & edge_cfg[2*WIDTH-1:WIDTH]);

    // Bits above the implemented fields are deliberately ignored
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        rd_mux = '0;
        unique case (bus.address)
            ADDR_DATA:     rd_mux[WIDTH-1:0]   = stable;
            ADDR_EDGE_CFG: rd_mux[2*WIDTH-1:0] = edge_cfg;
            ADDR_IRQMASK:  rd_mux[WIDTH-1:0]   = irqmask;
            ADDR_EDGECAP:  rd_mux[WIDTH-1:0]   = edgecapture;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d     <= '0;
            edge_cfg     <= '0;
            irqmask      <= '0;
            edgecapture  <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            stable_d <= stable;
            if (wr && bus.address == ADDR_EDGE_CFG) begin
                edge_cfg <= bus.writedata[2*WIDTH-1:0];
            end
            if (wr && bus.address == ADDR_IRQMASK) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
            // A new event wins over a same-cycle software clear
            edgecapture  <= ev | (edgecapture & ~clr);
            bus.readdata <= rd_mux;
            irq          <= |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_sw_edge_irq_ctrl.sv
// Directed bench for sw_edge_irq_ctrl with WIDTH=4, DEBOUNCE_CYCLES=4; inputs
// change on the falling edge and outputs are sampled there.
module tb_sw_edge_irq_ctrl;
    import sw_edge_irq_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = 4'h0;
    logic       irq;
    logic [31:0] rd;
    int checks = 0;
    int errors = 0;

    sw_edge_irq_ctrl_if bus ();

    sw_edge_irq_ctrl #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    task automatic test_reset;
        in_port = 4'hF;
        reset_n = 1'b0;
        tick(3);
        checks++;
        if (bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata got %h want %h", bus.readdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b want 0", irq);
        end
        bus.address = ADDR_DATA;
        reset_n = 1'b1;
        tick(3);
        checks++;
        if (bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data_c3 got %h want %h", bus.readdata, 32'h0);
        end
        tick(4);
        checks++;
        if (bus.readdata !== 32'hF) begin
            errors++;
            $display("FAIL reset_data_c7 got %h want %h", bus.readdata, 32'hF);
        end
        tick(3);
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_edgecap got %h want %h", rd, 32'h0);
        end
        bus_read(ADDR_EDGE_CFG, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_edge_cfg got %h want %h", rd, 32'h0);
        end
    endtask

    task automatic test_glitch;
        in_port = 4'h0;
        tick(10);
        in_port = 4'h1;
        tick(3);
        in_port = 4'h0;
        tick(10);
        bus_read(ADDR_DATA, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL glitch3_data got %h want %h", rd, 32'h0);
        end
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL glitch3_edgecap got %h want %h", rd, 32'h0);
        end
        // 4-cycle pulse: accepted at edge 6, visible on readdata after edge 7
        bus.address = ADDR_DATA;
        in_port = 4'h1;
        tick(4);
        in_port = 4'h0;
        tick(2);
        checks++;
        if (bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL pulse4_early got %h want %h", bus.readdata, 32'h0);
        end
        tick(1);
        checks++;
        if (bus.readdata !== 32'h1) begin
            errors++;
            $display("FAIL pulse4_accept got %h want %h", bus.readdata, 32'h1);
        end
        tick(12);
        bus_write(ADDR_DATA, 32'hF);
        bus_read(ADDR_DATA, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL data_ro got %h want %h", rd, 32'h0);
        end
    endtask

    task automatic test_edge_select;
        bus_write(ADDR_EDGE_CFG, 32'hFFFF_FFFF);
        bus_read(ADDR_EDGE_CFG, rd);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL edge_cfg_width got %h want %h", rd, 32'hFF);
        end
        bus_write(ADDR_EDGE_CFG, 32'h10);
        bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
        bus_read(ADDR_IRQMASK, rd);
        checks++;
        if (rd !== 32'hF) begin
            errors++;
            $display("FAIL irqmask_width got %h want %h", rd, 32'hF);
        end
        bus_write(ADDR_IRQMASK, 32'h1);
        in_port = 4'h1;
        tick(10);
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rise_ignored got %h want %h", rd, 32'h0);
        end
        in_port = 4'h0;
        tick(7);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL fall_irq_early got %b want 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL fall_irq got %b want 1", irq);
        end
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL fall_capture got %h want %h", rd, 32'h1);
        end
    endtask

    task automatic test_w1c;
        bus_write(ADDR_EDGE_CFG, 32'h14);
        in_port = 4'h4;
        tick(10);
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h5) begin
            errors++;
            $display("FAIL w1c_setup got %h want %h", rd, 32'h5);
        end
        bus_write(ADDR_EDGECAP, 32'h4);
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL w1c_bit2 got %h want %h", rd, 32'h1);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_irq_held got %b want 1", irq);
        end
        bus_write(ADDR_EDGECAP, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_irq_lag got %b want 1", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_irq_drop got %b want 0", irq);
        end
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL w1c_bit0 got %h want %h", rd, 32'h0);
        end
    endtask

    task automatic test_set_clear;
        bus_write(ADDR_EDGE_CFG, 32'h16);
        in_port = 4'h6;
        // Capture edge for bit1 is edge 7; the clear write lands on it
        tick(6);
        bus_write(ADDR_EDGECAP, 32'h2);
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL set_wins got %h want %h", rd, 32'h2);
        end
        bus_write(ADDR_IRQMASK, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_irq_lag got %b want 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_irq_rise got %b want 1", irq);
        end
        bus_write(ADDR_IRQMASK, 32'h0);
        tick(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_irq_fall got %b want 0", irq);
        end
        bus_write(ADDR_EDGECAP, 32'h2);
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL clear_bit1 got %h want %h", rd, 32'h0);
        end
    endtask

    task automatic test_reset_mid;
        bus_write(ADDR_EDGE_CFG, 32'hFF);
        bus_write(ADDR_IRQMASK, 32'hF);
        in_port = 4'h2;
        tick(10);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL mid_irq_before got %b want 1", irq);
        end
        bus.address = ADDR_DATA;
        in_port = 4'h3;
        tick(3);
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0 || bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got irq=%b rd=%h want irq=0 rd=0", irq, bus.readdata);
        end
        tick(2);
        reset_n = 1'b1;
        tick(6);
        checks++;
        if (bus.readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_early got %h want %h", bus.readdata, 32'h0);
        end
        tick(1);
        checks++;
        if (bus.readdata !== 32'h3) begin
            errors++;
            $display("FAIL mid_accept got %h want %h", bus.readdata, 32'h3);
        end
        bus_read(ADDR_IRQMASK, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_irqmask got %h want %h", rd, 32'h0);
        end
        bus_read(ADDR_EDGECAP, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_edgecap got %h want %h", rd, 32'h0);
        end
    endtask

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        test_reset();
        test_glitch();
        test_edge_select();
        test_w1c();
        test_set_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
